// File: rtl/inv_mix_columns_sched.sv
// inv_mix_columns_sched
// Time-shares one external 32-bit InvMixColumns column unit across the four
// columns of an AES-128 state. A state is accepted in IDLE, its columns are
// fed to the unit one per cycle (column 0 first), the results are assembled,
// and the finished state is held on the output until the downstream takes it.
// A bypass flag captured with the state skips the column unit entirely
// (final decryption round).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (ready only in IDLE)
//   in_state, in_bypass   state to transform, bypass flag
//   out_valid/out_ready   output handshake (valid only in DONE)
//   out_state             assembled result, stable while out_valid
//   col_data_o            column to the shared unit (zero outside BUSY)
//   col_res_i             unit result, combinational from col_data_o
//   busy, col_idx         BUSY indication and current column index
module inv_mix_columns_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [31:0]  col_data_o,
    input  logic [31:0]  col_res_i,
    output logic         busy,
    output logic [1:0]   col_idx
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_cnt;
    logic [127:0]  r_src;
    logic [127:0]  r_dst;
    logic          w_accept;
    logic [31:0]   w_col;

    assign w_accept = in_valid && (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = in_bypass ? S_DONE : S_BUSY;
            S_BUSY: if (r_cnt == 2'd3) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: source capture, destination assembly, column counter.
    // The counter wraps to 0 on the last column, so it already reads 0
    // when the FSM reaches DONE and no fifth write can occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_src <= '0;
            r_dst <= '0;
        end else if (w_accept) begin
            r_cnt <= 2'd0;
            r_src <= in_state;
            r_dst <= in_bypass ? in_state : '0;
        end else if (r_state == S_BUSY) begin
            for (int c = 0; c < 4; c++) begin
                if (r_cnt == c[1:0]) r_dst[127-32*c -: 32] <= col_res_i;
            end
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Column select; forced to zero outside BUSY so the shared unit sees
    // a quiet input when this block is not using it.
    always_comb begin
        w_col = 32'h0;
        if (r_state == S_BUSY) begin
            case (r_cnt)
                2'd0: w_col = r_src[127:96];
                2'd1: w_col = r_src[95:64];
                2'd2: w_col = r_src[63:32];
                default: w_col = r_src[31:0];
            endcase
        end
    end

    assign col_data_o = w_col;
    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state == S_BUSY);
    assign col_idx    = (r_state == S_BUSY) ? r_cnt : 2'd0;
    assign out_state  = r_dst;

endmodule

// File: tb/tb_inv_mix_columns_sched.sv
module tb_inv_mix_columns_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [31:0]  col_data_o;
    logic [31:0]  col_res_i;
    logic         busy;
    logic [1:0]   col_idx;

    logic         mode;      // 0: real InvMixColumns unit, 1: tagged identity
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    int           n_out = 0;
    logic [127:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_mix_columns_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_bypass(in_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .col_data_o(col_data_o), .col_res_i(col_res_i),
        .busy(busy), .col_idx(col_idx)
    );

    // External column unit model
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mc(input logic [31:0] c);
        logic [7:0] a[4], m9[4], m11[4], m13[4], m14[4];
        logic [7:0] b2, b4, b8;
        for (int i = 0; i < 4; i++) begin
            a[i] = c[31-8*i -: 8];
            b2 = xt(a[i]); b4 = xt(b2); b8 = xt(b4);
            m9[i]  = b8 ^ a[i];
            m11[i] = b8 ^ b2 ^ a[i];
            m13[i] = b8 ^ b4 ^ a[i];
            m14[i] = b8 ^ b4 ^ b2;
        end
        return {m14[0]^m11[1]^m13[2]^m9[3],
                m9[0]^m14[1]^m11[2]^m13[3],
                m13[0]^m9[1]^m14[2]^m11[3],
                m11[0]^m13[1]^m9[2]^m14[3]};
    endfunction

    assign col_res_i = mode ? (col_data_o ^ 32'h0000000c ^ {30'b0, col_idx})
                            : inv_mc(col_data_o);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compares on every output handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_output: got %h expected none", out_state);
            end else begin
                chk("out_state", out_state, sb.pop_front());
                chk("ready_valid_excl", {127'b0, in_ready}, 128'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
        if (in_ready !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle_timeout: got in_ready=%b expected 1", in_ready);
        end
    endtask

    // Accept one non-bypass state and follow it column by column to DONE
    task automatic do_xform(input logic [127:0] v, input logic [127:0] exp);
        wait_idle();
        in_valid = 1'b1; in_state = v; in_bypass = 1'b0;
        sb.push_back(exp);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("busy", {127'b0, busy}, 128'd1);
            chk("col_idx", {126'b0, col_idx}, c);
            chk("col_data", {96'b0, col_data_o}, {96'b0, v[127-32*c -: 32]});
            chk("early_valid", {127'b0, out_valid}, 128'd0);
            tick();
        end
        chk("valid_lat4", {127'b0, out_valid}, 128'd1);
        chk("busy_done", {127'b0, busy}, 128'd0);
    endtask

    logic [127:0] vec[3];
    logic [127:0] gold[3];
    int           acc[3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_bypass = 1'b0;
        out_ready = 1'b0; mode = 1'b0;
        tick(); tick();
        // reset state
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        chk("rst_col_data", {96'b0, col_data_o}, 128'd0);
        chk("rst_busy_idx", {125'b0, busy, col_idx}, 128'd0);
        rst_n = 1'b1;
        tick();

        // single transform
        out_ready = 1'b1;
        do_xform(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        tick();
        chk("idle_after_hs", {127'b0, in_ready}, 128'd1);

        // bypass
        in_valid = 1'b1; in_state = 128'h00112233_44556677_8899aabb_ccddeeff; in_bypass = 1'b1;
        sb.push_back(128'h00112233_44556677_8899aabb_ccddeeff);
        tick();
        in_valid = 1'b0; in_bypass = 1'b0;
        chk("byp_valid", {127'b0, out_valid}, 128'd1);
        chk("byp_busy", {127'b0, busy}, 128'd0);
        chk("byp_col_data", {96'b0, col_data_o}, 128'd0);
        tick();
        chk("byp_idle", {127'b0, in_ready}, 128'd1);

        // backpressure
        out_ready = 1'b0;
        do_xform(128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_01010101,
                 128'h2d26314c_d4d4d4d5_c6c6c6c6_01010101);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_state = {4{$urandom}}; in_bypass = i[1];
            chk("bp_valid", {127'b0, out_valid}, 128'd1);
            chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
            chk("bp_state", out_state, 128'h2d26314c_d4d4d4d5_c6c6c6c6_01010101);
            tick();
        end
        in_valid = 1'b0; in_bypass = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", {127'b0, in_ready}, 128'd1);
        chk("bp_release_valid", {127'b0, out_valid}, 128'd0);

        // back-to-back with in_valid held
        vec[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        gold[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        vec[1]  = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;
        gold[1] = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;
        vec[2]  = 128'h9fdc589d_8e4da1bc_c6c6c6c6_01010101;
        gold[2] = 128'hf20a225c_db135345_c6c6c6c6_01010101;
        in_valid = 1'b1; in_bypass = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_state = vec[k];
            wait_idle();
            sb.push_back(gold[k]);
            acc[k] = cyc;
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_gap01", acc[1] - acc[0], 128'd6);
        chk("b2b_gap12", acc[2] - acc[1], 128'd6);
        wait_idle();

        // column ordering with a tagged identity unit
        mode = 1'b1;
        do_xform(128'h11111111_22222222_33333333_44444444,
                 128'h1111111d_2222222f_3333333d_4444444b);
        tick();
        wait_idle();
        mode = 1'b0;

        chk("sb_empty", sb.size(), 128'd0);
        chk("out_count", n_out, 128'd7);

        // reset mid-BUSY
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {127'b0, out_valid}, 128'd0);
        chk("abort_busy", {127'b0, busy}, 128'd0);
        chk("abort_col_data", {96'b0, col_data_o}, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
        chk("abort_out_state", out_state, 128'd0);
        chk("abort_col_idx", {126'b0, col_idx}, 128'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
